// File: rtl/addsub_arbiter_ctrl.sv
// Round-robin front end that shares one external add_subtract datapath between two requesters.
// Optional signed-overflow detection is compiled in when ADDSUB_OVF_DETECT_EN is defined.
module addsub_arbiter_ctrl #(
    parameter int N     = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [N-1:0]     req_a0,
    input  logic [N-1:0]     req_b0,
    input  logic             req_op0,
    input  logic             req_cin0,
    input  logic [N-1:0]     req_a1,
    input  logic [N-1:0]     req_b1,
    input  logic             req_op1,
    input  logic             req_cin1,
    output logic [N-1:0]     dp_a,
    output logic [N-1:0]     dp_b,
    output logic             dp_flag,
    output logic             dp_cin,
    input  logic [N-1:0]     dp_s,
    input  logic             dp_cout,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [N-1:0]     resp_s,
    output logic             resp_cout,
    output logic             resp_ovf,
    output logic [CNT_W-1:0] op_count
);

    localparam int MSB = N - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q;
    logic             rr_ptr_q;
    logic             granted_q;
    logic [N-1:0]     dp_a_q;
    logic [N-1:0]     dp_b_q;
    logic             dp_flag_q;
    logic             dp_cin_q;
    logic             resp_valid_q;
    logic             resp_id_q;
    logic [N-1:0]     resp_s_q;
    logic             resp_cout_q;
    logic             resp_ovf_q;
    logic [CNT_W-1:0] op_count_q;

    logic [1:0]       grant;
    logic             gnt_id;
    logic             xfer;
    logic             ovf_d;

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        grant = 2'b00;
        case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            // Contention: requester 0 first after reset, then whoever was not served last.
            2'b11:   grant = (!granted_q || rr_ptr_q) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    assign req_ready = (state_q == IDLE && !rst) ? grant : 2'b00;
    assign gnt_id    = grant[1];
    assign xfer      = |(req_valid & req_ready);

`ifdef ADDSUB_OVF_DETECT_EN
    always_comb begin
        ovf_d = 1'b0;
        if (dp_flag_q)
            ovf_d = (dp_a_q[MSB] == dp_b_q[MSB]) && (dp_s[MSB] != dp_a_q[MSB]);
        else
            ovf_d = (dp_a_q[MSB] != dp_b_q[MSB]) && (dp_s[MSB] != dp_a_q[MSB]);
    end
`else
    assign ovf_d = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            rr_ptr_q     <= 1'b0;
            granted_q    <= 1'b0;
            dp_a_q       <= '0;
            dp_b_q       <= '0;
            dp_flag_q    <= 1'b0;
            dp_cin_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= 1'b0;
            resp_s_q     <= '0;
            resp_cout_q  <= 1'b0;
            resp_ovf_q   <= 1'b0;
            op_count_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (xfer) begin
                        dp_a_q    <= gnt_id ? req_a1   : req_a0;
                        dp_b_q    <= gnt_id ? req_b1   : req_b0;
                        dp_flag_q <= gnt_id ? req_op1  : req_op0;
                        dp_cin_q  <= gnt_id ? req_cin1 : req_cin0;
                        rr_ptr_q  <= gnt_id;
                        granted_q <= 1'b1;
                        state_q   <= EXEC;
                    end
                end
                EXEC: begin
                    resp_s_q     <= dp_s;
                    resp_cout_q  <= dp_cout;
                    resp_ovf_q   <= ovf_d;
                    resp_id_q    <= rr_ptr_q;
                    resp_valid_q <= 1'b1;
                    state_q      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        op_count_q   <= op_count_q + CNT_W'(1);
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dp_a       = dp_a_q;
    assign dp_b       = dp_b_q;
    assign dp_flag    = dp_flag_q;
    assign dp_cin     = dp_cin_q;
    assign resp_valid = resp_valid_q;
    assign resp_id    = resp_id_q;
    assign resp_s     = resp_s_q;
    assign resp_cout  = resp_cout_q;
    assign resp_ovf   = resp_ovf_q;
    assign op_count   = op_count_q;

endmodule

// File: tb/tb_addsub_arbiter_ctrl.sv
// Scoreboard bench for addsub_arbiter_ctrl with a behavioural add/sub datapath stub.
// Honours ADDSUB_OVF_DETECT_EN when forming expected overflow flags.
module tb_addsub_arbiter_ctrl;

    localparam int N     = 32;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [1:0]       req_valid = 2'b00;
    logic [1:0]       req_ready;
    logic [N-1:0]     req_a0 = '0, req_b0 = '0, req_a1 = '0, req_b1 = '0;
    logic             req_op0 = 1'b0, req_cin0 = 1'b0, req_op1 = 1'b0, req_cin1 = 1'b0;
    logic [N-1:0]     dp_a, dp_b, dp_s;
    logic             dp_flag, dp_cin, dp_cout;
    logic             resp_valid;
    logic             resp_ready = 1'b1;
    logic             resp_id;
    logic [N-1:0]     resp_s;
    logic             resp_cout, resp_ovf;
    logic [CNT_W-1:0] op_count;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    typedef struct packed {
        logic         id;
        logic [N-1:0] s;
        logic         cout;
        logic         ovf;
    } resp_t;

    resp_t sb[$];
    bit    m_first = 1'b1;
    bit    m_last  = 1'b0;
    int    m_age   = 0;
    int    m_count = 0;

    addsub_arbiter_ctrl #(.N(N), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a0(req_a0), .req_b0(req_b0), .req_op0(req_op0), .req_cin0(req_cin0),
        .req_a1(req_a1), .req_b1(req_b1), .req_op1(req_op1), .req_cin1(req_cin1),
        .dp_a(dp_a), .dp_b(dp_b), .dp_flag(dp_flag), .dp_cin(dp_cin),
        .dp_s(dp_s), .dp_cout(dp_cout),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_s(resp_s), .resp_cout(resp_cout), .resp_ovf(resp_ovf),
        .op_count(op_count)
    );

    always #5 clk = ~clk;

    // Stand-in for the external add_subtract block: subtract is A + ~B + 1 + Cin.
    logic [N:0] dp_t;
    always_comb begin
        dp_t = '0;
        if (dp_flag) dp_t = {1'b0, dp_a} + {1'b0, dp_b} + 33'(dp_cin);
        else         dp_t = {1'b0, dp_a} + {1'b0, ~dp_b} + 33'd1 + 33'(dp_cin);
    end
    assign dp_s    = dp_t[N-1:0];
    assign dp_cout = dp_t[N];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic resp_t ref_op(input logic id, input logic [N-1:0] a, input logic [N-1:0] b,
                                     input logic op, input logic cin);
        resp_t  r;
        longint v;
        if (op) v = longint'(a) + longint'(b) + longint'(cin);
        else    v = longint'(a) - longint'(b) + longint'(cin) + (longint'(1) << N);
        r.id   = id;
        r.s    = v[N-1:0];
        r.cout = v[N];
`ifdef ADDSUB_OVF_DETECT_EN
        if (op) r.ovf = (a[N-1] == b[N-1]) && (r.s[N-1] != a[N-1]);
        else    r.ovf = (a[N-1] != b[N-1]) && (r.s[N-1] != a[N-1]);
`else
        r.ovf = 1'b0;
`endif
        return r;
    endfunction

    // Monitor: reference model of arbitration/latency plus scoreboard pop on each handshake.
    always @(negedge clk) begin
        if (mon_en) begin
            logic [1:0] exp_ready;
            logic       win;
            resp_t      e;
            if (sb.size() != 0) m_age++;
            exp_ready = 2'b00;
            win = 1'b0;
            if (sb.size() == 0 && !rst && req_valid != 2'b00) begin
                if (req_valid == 2'b11) win = m_first ? 1'b0 : ~m_last;
                else                    win = req_valid[1];
                exp_ready = win ? 2'b10 : 2'b01;
            end
            check("req_ready", 64'(req_ready), 64'(exp_ready));
            check("resp_valid", 64'(resp_valid), 64'(sb.size() != 0 && m_age >= 2));
            check("op_count", 64'(op_count), 64'(m_count % (1 << CNT_W)));
            if (rst) begin
                sb.delete();
                m_first = 1'b1;
                m_last  = 1'b0;
                m_age   = 0;
                m_count = 0;
            end else if (resp_valid && resp_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_resp", 64'(1), 64'(0));
                end else begin
                    e = sb.pop_front();
                    check("resp_id", 64'(resp_id), 64'(e.id));
                    check("resp_s", 64'(resp_s), 64'(e.s));
                    check("resp_cout", 64'(resp_cout), 64'(e.cout));
                    check("resp_ovf", 64'(resp_ovf), 64'(e.ovf));
                    m_count++;
                end
            end else if (exp_ready != 2'b00) begin
                if (win) sb.push_back(ref_op(1'b1, req_a1, req_b1, req_op1, req_cin1));
                else     sb.push_back(ref_op(1'b0, req_a0, req_b0, req_op0, req_cin0));
                m_first = 1'b0;
                m_last  = win;
                m_age   = 0;
            end
        end
    end

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic id, input logic [N-1:0] a, input logic [N-1:0] b,
                           input logic op, input logic cin);
        if (id) begin req_a1 = a; req_b1 = b; req_op1 = op; req_cin1 = cin; end
        else    begin req_a0 = a; req_b0 = b; req_op0 = op; req_cin0 = cin; end
    endtask

    // Raise one request, wait for its transfer edge, then drop it.
    task automatic issue(input logic id, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic op, input logic cin);
        bit done = 1'b0;
        set_req(id, a, b, op, cin);
        req_valid[id] = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (req_ready[id]) done = 1'b1;
        end
        if (!done) check("issue_timeout", 64'(0), 64'(1));
        drive_edge();
        req_valid[id] = 1'b0;
    endtask

    task automatic wait_drain();
        bit done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !resp_valid) done = 1'b1;
        end
        if (!done) check("drain_timeout", 64'(0), 64'(1));
        drive_edge();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_xfer;
        // Reset for two clocks, then confirm every reset value.
        rst = 1'b1;
        drive_edge();
        drive_edge();
        rst    = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        check("rst_dp_a", 64'(dp_a), 64'(0));
        check("rst_dp_b", 64'(dp_b), 64'(0));
        check("rst_dp_flag_cin", 64'({dp_flag, dp_cin}), 64'(0));
        check("rst_resp", 64'({resp_id, resp_cout, resp_ovf}), 64'(0));
        check("rst_resp_s", 64'(resp_s), 64'(0));
        drive_edge();

        // Basic add on requester 0 and subtract on requester 1.
        issue(1'b0, 32'd75, 32'd25, 1'b1, 1'b0);
        wait_drain();
        check("dp_a_held", 64'(dp_a), 64'(75));
        check("dp_b_held", 64'(dp_b), 64'(25));
        issue(1'b1, 32'd75, 32'd25, 1'b0, 1'b0);
        wait_drain();
        issue(1'b0, 32'd75, 32'd25, 1'b0, 1'b1);
        wait_drain();

        // Both requesters continuously valid: grants must alternate.
        set_req(1'b0, 32'd1000, 32'd1, 1'b1, 1'b0);
        set_req(1'b1, 32'd5, 32'd9, 1'b0, 1'b0);
        req_valid = 2'b11;
        n_xfer = 0;
        for (int i = 0; i < 100 && n_xfer < 8; i++) begin
            @(negedge clk);
            if (req_ready != 2'b00) n_xfer++;
            check("ready_onehot", 64'(req_ready == 2'b11), 64'(0));
        end
        check("alternate_count", 64'(n_xfer), 64'(8));
        drive_edge();
        req_valid = 2'b00;
        wait_drain();

        // Back-pressure: response must hold while resp_ready is low.
        resp_ready = 1'b0;
        issue(1'b1, 32'hDEADBEEF, 32'h12345678, 1'b1, 1'b1);
        req_valid = 2'b11;
        drive_edge();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_valid", 64'(resp_valid), 64'(1));
            if (sb.size() != 0) begin
                check("hold_s", 64'(resp_s), 64'(sb[0].s));
                check("hold_id", 64'(resp_id), 64'(sb[0].id));
                check("hold_cout", 64'(resp_cout), 64'(sb[0].cout));
            end
        end
        drive_edge();
        resp_ready = 1'b1;
        req_valid  = 2'b00;
        wait_drain();

        // Reset during EXEC discards the in-flight op and clears the counter.
        issue(1'b0, 32'd7, 32'd3, 1'b1, 1'b0);
        rst = 1'b1;
        drive_edge();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_valid", 64'(resp_valid), 64'(0));
        check("post_rst_count", 64'(op_count), 64'(0));
        for (int i = 0; i < 4; i++) drive_edge();

        // Overflow corner cases.
        issue(1'b0, 32'h7FFFFFFF, 32'd1, 1'b1, 1'b0);
        wait_drain();
        issue(1'b1, 32'd0, 32'd1, 1'b0, 1'b0);
        wait_drain();

        // Random traffic with back-pressure and occasional reset; wraps the 4-bit counter.
        for (int i = 0; i < 1500; i++) begin
            req_valid  = 2'($urandom);
            req_a0     = $urandom;
            req_b0     = ($urandom_range(0, 3) == 0) ? 32'h80000000 : $urandom;
            req_op0    = 1'($urandom);
            req_cin0   = 1'($urandom);
            req_a1     = $urandom;
            req_b1     = $urandom;
            req_op1    = 1'($urandom);
            req_cin1   = 1'($urandom);
            resp_ready = ($urandom_range(0, 3) != 0);
            rst        = ($urandom_range(0, 299) == 0);
            drive_edge();
        end
        rst        = 1'b0;
        req_valid  = 2'b00;
        resp_ready = 1'b1;
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
